// File: rtl/multicycle_controller_pkg.sv
// ctrl_pkg: opcode, state and PC-source encodings shared by the multi-cycle controller.
package ctrl_pkg;
    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_JUMP  = 4'b0010;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_WIN   = 4'b1000;
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd5
    } state_t;
    localparam logic [1:0] PCSRC_INC = 2'd0;
    localparam logic [1:0] PCSRC_BR  = 2'd1;
    localparam logic [1:0] PCSRC_JMP = 2'd2;
    function automatic logic is_alui(input logic [3:0] op);
        return !(op inside {OP_LOAD, OP_STORE, OP_JUMP, OP_BEQ, OP_WIN});
    endfunction
endpackage

// File: rtl/multicycle_controller_wait_timer.sv
// wait_timer: saturating wait counter that flags when the count reaches TIMEOUT.
module wait_timer #(
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && cnt != '1) cnt <= cnt + 1'b1;
    end
    assign timeout = cnt == CNT_W'(TIMEOUT);
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: fetch/decode/exec/mem/writeback sequencer with memory-handshake timeout.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       imAck,
    input  logic       dmAck,
    output logic       imReq,
    output logic       dmReq,
    output logic       irWrite,
    output logic       pcWrite,
    output logic [1:0] pcSrc,
    output logic       selImm,
    output logic       selMemOut,
    output logic       readDM,
    output logic       writeDM,
    output logic       writeFR,
    output logic       winUpdate,
    output logic       busy,
    output logic       err
);
    state_t     state;
    logic [3:0] op_reg;
    logic       timeout;
    logic       in_wait, ack;
    assign in_wait = state == S_FETCH || state == S_MEM;
    assign ack     = state == S_FETCH ? imAck : dmAck;
    // counter restarts whenever a wait state is left or not occupied
    wait_timer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!in_wait || ack || timeout),
        .en      (in_wait),
        .timeout (timeout)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_FETCH;
            op_reg <= '0;
        end else begin
            case (state)
                S_FETCH:  state <= imAck ? S_DECODE : timeout ? S_ERR : S_FETCH;
                S_DECODE: begin
                    op_reg <= opcode;
                    state  <= S_EXEC;
                end
                S_EXEC:   state <= (op_reg == OP_JUMP || op_reg == OP_BEQ) ? S_FETCH :
                                   (op_reg == OP_LOAD || op_reg == OP_STORE) ? S_MEM : S_WB;
                S_MEM:    state <= dmAck ? (op_reg == OP_LOAD ? S_WB : S_FETCH) :
                                   timeout ? S_ERR : S_MEM;
                S_WB:     state <= S_FETCH;
                default:  state <= S_ERR;
            endcase
        end
    end
    // every output is forced low while reset is asserted
    logic f, e, m, w;
    assign f = rst_n && state == S_FETCH;
    assign e = rst_n && state == S_EXEC;
    assign m = rst_n && state == S_MEM;
    assign w = rst_n && state == S_WB;
    assign imReq     = f;
    assign irWrite   = f && imAck;
    assign pcWrite   = (f && imAck) || (e && (op_reg == OP_JUMP || (op_reg == OP_BEQ && zero)));
    assign pcSrc     = (e && op_reg == OP_JUMP) ? PCSRC_JMP : (e && op_reg == OP_BEQ) ? PCSRC_BR : PCSRC_INC;
    assign selImm    = (e || w) && is_alui(op_reg);
    assign selMemOut = w && op_reg == OP_LOAD;
    assign dmReq     = m;
    assign readDM    = m && op_reg == OP_LOAD;
    assign writeDM   = m && op_reg == OP_STORE;
    assign writeFR   = w;
    assign winUpdate = w && op_reg == OP_WIN;
    assign busy      = rst_n && state != S_ERR;
    assign err       = rst_n && state == S_ERR;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: trace-model bench; each instruction expands into per-cycle stimulus and expected outputs.
module tb_multicycle_controller;
    localparam int TO = 15;
    localparam logic [3:0] LD = 4'b0000, ST = 4'b0001, JP = 4'b0010, BQ = 4'b0100, WN = 4'b1000;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [3:0] opcode = '0;
    logic zero = 1'b0, imAck = 1'b0, dmAck = 1'b0;
    logic imReq, dmReq, irWrite, pcWrite, selImm, selMemOut, readDM, writeDM, writeFR, winUpdate, busy, err;
    logic [1:0] pcSrc;
    int total = 0, bad = 0;
    typedef struct {
        logic       ia, da, z;
        logic [3:0] op;
        logic [13:0] exp;
    } cyc_t;
    cyc_t q[$];
    multicycle_controller #(.TIMEOUT(TO), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .imAck(imAck), .dmAck(dmAck),
        .imReq(imReq), .dmReq(dmReq), .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc),
        .selImm(selImm), .selMemOut(selMemOut), .readDM(readDM), .writeDM(writeDM),
        .writeFR(writeFR), .winUpdate(winUpdate), .busy(busy), .err(err)
    );
    always #5 clk = ~clk;
    function automatic logic [13:0] outs();
        return {imReq, dmReq, irWrite, pcWrite, pcSrc, selImm, selMemOut, readDM, writeDM, writeFR, winUpdate, busy, err};
    endfunction
    function automatic logic [13:0] ov(logic im, dm, ir, pw, logic [1:0] ps, logic si, smo, rd, wr, wf, wu, bz, er);
        return {im, dm, ir, pw, ps, si, smo, rd, wr, wf, wu, bz, er};
    endfunction
    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction
    function automatic logic [3:0] rop();
        return 4'($urandom_range(0, 15));
    endfunction
    task automatic chk(input string name, input logic [13:0] got, input logic [13:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
        end
    endtask
    task automatic push(input logic ia, da, z, input logic [3:0] op, input logic [13:0] exp);
        q.push_back('{ia, da, z, op, exp});
    endtask
    task automatic push_err(input int n);
        for (int i = 0; i < n; i++) push(rb(), rb(), rb(), rop(), ov(0,0,0,0,0,0,0,0,0,0,0,0,1));
    endtask
    // fd/dd: cycles of missing ack before the ack arrives; beyond TO the access traps
    task automatic gen(input logic [3:0] op, input int fd, input int dd, input logic z);
        logic alui = !(op inside {LD, ST, JP, BQ, WN});
        logic ls = op == LD || op == ST;
        for (int i = 0; i < (fd > TO ? TO + 1 : fd); i++) push(0, rb(), rb(), rop(), ov(1,0,0,0,0,0,0,0,0,0,0,1,0));
        if (fd > TO) begin push_err(4); return; end
        push(1, rb(), rb(), rop(), ov(1,0,1,1,0,0,0,0,0,0,0,1,0));
        push(rb(), rb(), rb(), op, ov(0,0,0,0,0,0,0,0,0,0,0,1,0));
        push(rb(), rb(), z, rop(), ov(0,0,0, op == JP || (op == BQ && z), op == JP ? 2'd2 : op == BQ ? 2'd1 : 2'd0,
                                      alui,0,0,0,0,0,1,0));
        if (op == JP || op == BQ) return;
        if (ls) begin
            for (int i = 0; i < (dd > TO ? TO + 1 : dd); i++) push(rb(), 0, rb(), rop(), ov(0,1,0,0,0,0,0,op == LD,op == ST,0,0,1,0));
            if (dd > TO) begin push_err(4); return; end
            push(rb(), 1, rb(), rop(), ov(0,1,0,0,0,0,0,op == LD,op == ST,0,0,1,0));
            if (op == ST) return;
        end
        push(rb(), rb(), rb(), rop(), ov(0,0,0,0,0,alui,op == LD,0,0,1,op == WN,1,0));
    endtask
    task automatic gen_lat(input string name, input logic [3:0] op, input int lat);
        int n0 = q.size();
        gen(op, 0, 0, 1'b0);
        total++;
        if (q.size() - n0 != lat) begin
            bad++;
            $display("FAIL lat_%s got=%0d exp=%0d", name, q.size() - n0, lat);
        end
    endtask
    // entered and left at posedge+1
    task automatic run(input int n);
        cyc_t c;
        for (int i = 0; (n < 0 || i < n) && q.size() > 0; i++) begin
            c = q.pop_front();
            imAck = c.ia; dmAck = c.da; zero = c.z; opcode = c.op;
            @(negedge clk);
            chk("trace", outs(), c.exp);
            @(posedge clk); #1;
        end
    endtask
    task automatic do_reset();
        rst_n = 1'b0; imAck = 1'b0; dmAck = 1'b0;
        #2 chk("rst_zero", outs(), '0);
        @(posedge clk); #1 rst_n = 1'b1;
        #1 chk("rst_fetch", outs(), ov(1,0,0,0,0,0,0,0,0,0,0,1,0));
    endtask
    initial begin
        #1 chk("por_zero", outs(), '0);
        @(posedge clk); #1 rst_n = 1'b1;
        imAck = 1'b1; opcode = 4'b0011;
        @(negedge clk);
        chk("c1_irwrite", {13'd0, irWrite}, 14'd1);
        chk("c1_pcwrite", {13'd0, pcWrite}, 14'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("c2_decode", {12'd0, imReq, irWrite}, 14'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("c3_exec", {12'd0, selImm, writeFR}, 14'b10);
        @(posedge clk); #1;
        @(negedge clk);
        chk("c4_wb", {12'd0, selImm, writeFR}, 14'b11);
        @(posedge clk); #1 imAck = 1'b0;
        gen_lat("alui", 4'b0011, 4);
        gen_lat("load", LD, 5);
        gen_lat("jump", JP, 3);
        gen_lat("store", ST, 4);
        gen_lat("win", WN, 4);
        gen(LD, 1, 3, 1'b0);
        gen(BQ, 0, 0, 1'b1);
        gen(BQ, 2, 0, 1'b0);
        gen(4'b1111, 0, 0, 1'b0);
        gen(ST, 0, TO, 1'b0);
        gen(LD, TO, TO, 1'b1);
        gen(4'b0110, 3, 0, 1'b1);
        run(-1);
        gen(ST, 0, 99, 1'b0);
        run(-1);
        do_reset();
        gen(JP, TO + 1, 0, 1'b0);
        run(-1);
        do_reset();
        gen(ST, 0, 10, 1'b0);
        run(5);
        q.delete();
        dmAck = 1'b0;
        #2 chk("mem_writedm", {13'd0, writeDM}, 14'd1);
        rst_n = 1'b0;
        #1 chk("async_drop", outs(), '0);
        @(posedge clk); #1 rst_n = 1'b1;
        gen(4'b0101, 0, 0, 1'b0);
        gen(LD, 0, 0, 1'b0);
        run(-1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
